led_reg_file: RTL and testbench
===============================

Name: led_reg_file

Overview:
- Upstream register bank for the LED controller. It takes the byte stream from the serial host front-end, which presents a start pulse, a control byte, then data bytes.
- It holds the PCA963x-style register map and drives the configuration outputs consumed by group_pwm (grp_pwm_reg, grp_freq_reg, dim_blink) and by the per-LED PWM and output stages.
- It supports write, readback and an auto-incrementing register pointer.

Parameters:
- DATA_BITS, default 8 (from led_driver_pkg): register and bus byte width.
- NUM_REGS, default 13: number of implemented registers, addresses 0x0–0xC.

Ports:
- glb.clk  in  1  system clock, carried on global_if glb.
- glb.rst_n  in  1  synchronous, active-low reset, carried on global_if glb.
- bus_start  in  1  one-cycle pulse: transaction start (start or repeated start).
- bus_stop  in  1  one-cycle pulse: transaction end.
- wr_valid  in  1  wr_data holds a host byte this cycle.
- wr_data  in  DATA_BITS  host byte.
- rd_req  in  1  host requests one readback byte.
- rd_data  out  DATA_BITS  readback byte.
- rd_valid  out  1  rd_data valid (one-cycle pulse).
- mode1_reg, mode2_reg  out  DATA_BITS  mode registers.
- pwm_reg  out  4 x DATA_BITS  individual duty registers PWM0..PWM3.
- grp_pwm_reg, grp_freq_reg  out  DATA_BITS  to group_pwm.
- ledout_reg  out  DATA_BITS  LED output select, 2 bits per LED.
- dim_blink  out  1  = mode2_reg[5] (DMBLNK).
- addr_err  out  1  sticky: an invalid pointer was loaded in this transaction.

Behaviour:
- Register map:
  - 0 MODE1, 1 MODE2, 2–5 PWM0–3, 6 GRPPWM, 7 GRPFREQ, 8 LEDOUT.
  - 9–B SUBADR1–3, C ALLCALLADR.
- Reset values, applied on any clock edge with glb.rst_n=0:
  - MODE1=0x11, MODE2=0x01, PWM0–3=0x00, GRPPWM=0xFF, GRPFREQ=0x00, LEDOUT=0x00.
  - SUBADR1/2/3=0xE2/0xE4/0xE8, ALLCALLADR=0xE0.
  - ptr=0, ai=0, rd_valid=0, rd_data=0, addr_err=0, state=IDLE.
- Reset mid-transaction discards the transaction and restores all of the above.
- FSM states are IDLE, CTRL and DATA.
  - bus_start in any state → CTRL and clears addr_err.
  - bus_stop in any state → IDLE.
- CTRL + wr_valid → DATA:
  - ptr ← wr_data[3:0], ai ← wr_data[7].
  - If wr_data[3:0] > 0xC, addr_err ← 1.
  - The control byte is never written to a register.
- DATA + wr_valid:
  - If ptr ≤ 0xC, reg[ptr] ← wr_data. The new value appears on the outputs the next cycle.
  - MODE2[7:6] are reserved: written as don't-care, stored and read back as 0.
  - If ptr > 0xC, the write is ignored.
- DATA + rd_req: rd_data ← reg[ptr] (0x00 if ptr > 0xC), and rd_valid=1 the next cycle.
- rd_req outside DATA: rd_valid stays 0.
- Pointer advance happens after each data write or read, only when ai=1:
  - ptr ← (ptr==0xC) ? 0x0 : ptr+1.
  - ptr > 0xC does not advance.
  - ai=0 leaves ptr unchanged.
- Simultaneous events:
  - bus_start together with wr_valid or rd_req: start wins and the byte/request is dropped.
  - bus_stop together with wr_valid in DATA: the write completes, then IDLE.
  - wr_valid together with rd_req: the write wins, the read is dropped, ptr advances once.
- wr_valid and rd_req in IDLE are ignored.
- All outputs are registered. dim_blink is a direct wire from the mode2 storage bit.

Optional Feature:
LED_REG_READBACK_EN:
- Defined: read path as above.
- Undefined:
  - rd_req is ignored.
  - rd_valid and rd_data are tied to 0.
  - No read mux is synthesized.
  - Write-side behaviour is unchanged.

Decomposition:
- led_driver_pkg additions:
  - reg_addr_t enum (REG_MODE1..REG_ALLCALLADR).
  - NUM_REGS and LAST_REG_ADDR=4'hC.
  - Per-register reset constants.
  - regfile_state_t enum {IDLE, CTRL, DATA}.
- One sub-module, reg_pointer: ptr/ai storage, load, auto-increment and wrap. Its interface is load, load_val, adv, ptr, ai.

Test Plan:
- Reset: glb.rst_n=0 for 2 clk → grp_pwm_reg=0xFF, grp_freq_reg=0x00, mode1_reg=0x11, dim_blink=0, rd_valid=0.
- Auto-inc burst: start, ctrl 0x86, data 0x40,0x17 → grp_pwm_reg=0x40, grp_freq_reg=0x17, ptr=8.
- Wrap: start, ctrl 0x8C, data 0xE6,0x01 → ALLCALLADR=0xE6, MODE1=0x01.
- No-AI plus dim_blink: start, ctrl 0x01, data 0x20,0xE5 → MODE2=0x25 (last write, bits 7:6 cleared), dim_blink=1, ptr stays 1.
- Invalid address: ctrl 0x8E, data 0x55 → addr_err=1, no register changes. A subsequent bus_start clears addr_err.
- Readback (LED_REG_READBACK_EN): start, ctrl 0x82, rd_req x4 → rd_data=PWM0..PWM3 on consecutive rd_valid pulses. Same cycle start+rd_req → no rd_valid.

Source files
------------

// File: rtl/led_driver_pkg.sv
// rtl/led_driver_pkg.sv - shared types, register map and reset constants for the LED driver
package led_driver_pkg;

    localparam int DATA_BITS = 8;
    localparam int NUM_REGS  = 13;

    localparam logic [3:0] LAST_REG_ADDR = 4'hC;

    typedef enum logic [3:0] {
        REG_MODE1      = 4'h0,
        REG_MODE2      = 4'h1,
        REG_PWM0       = 4'h2,
        REG_PWM1       = 4'h3,
        REG_PWM2       = 4'h4,
        REG_PWM3       = 4'h5,
        REG_GRPPWM     = 4'h6,
        REG_GRPFREQ    = 4'h7,
        REG_LEDOUT     = 4'h8,
        REG_SUBADR1    = 4'h9,
        REG_SUBADR2    = 4'hA,
        REG_SUBADR3    = 4'hB,
        REG_ALLCALLADR = 4'hC
    } reg_addr_t;

    localparam logic [7:0] RST_MODE1      = 8'h11;
    localparam logic [7:0] RST_MODE2      = 8'h01;
    localparam logic [7:0] RST_PWM        = 8'h00;
    localparam logic [7:0] RST_GRPPWM     = 8'hFF;
    localparam logic [7:0] RST_GRPFREQ    = 8'h00;
    localparam logic [7:0] RST_LEDOUT     = 8'h00;
    localparam logic [7:0] RST_SUBADR1    = 8'hE2;
    localparam logic [7:0] RST_SUBADR2    = 8'hE4;
    localparam logic [7:0] RST_SUBADR3    = 8'hE8;
    localparam logic [7:0] RST_ALLCALLADR = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        DATA = 2'd2
    } regfile_state_t;

    // Reset value of the register at address a; unimplemented addresses read as zero.
    function automatic logic [7:0] reg_reset_val(input logic [3:0] a);
        case (a)
            REG_MODE1:      return RST_MODE1;
            REG_MODE2:      return RST_MODE2;
            REG_GRPPWM:     return RST_GRPPWM;
            REG_GRPFREQ:    return RST_GRPFREQ;
            REG_LEDOUT:     return RST_LEDOUT;
            REG_SUBADR1:    return RST_SUBADR1;
            REG_SUBADR2:    return RST_SUBADR2;
            REG_SUBADR3:    return RST_SUBADR3;
            REG_ALLCALLADR: return RST_ALLCALLADR;
            default:        return RST_PWM;
        endcase
    endfunction

endpackage

// File: rtl/global_if.sv
// rtl/global_if.sv - global clock and synchronous active-low reset bundle
interface global_if;
    logic clk;
    logic rst_n;

    modport sink (input clk, input rst_n);
endinterface

// File: rtl/reg_pointer.sv
// rtl/reg_pointer.sv - register pointer with load, auto-increment and wrap at the last register
module reg_pointer
    import led_driver_pkg::*;
(
    global_if.sink     glb,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       adv,
    output logic [3:0] ptr,
    output logic       ai
);

    logic [3:0] ptr_q, ptr_d;
    logic       ai_q, ai_d;

    // Load takes priority; an out-of-map pointer is frozen so it never wraps back into the map.
    always_comb begin
        ptr_d = ptr_q;
        ai_d  = ai_q;
        if (load) begin
            ai_d  = load_val[4];
            ptr_d = load_val[3:0];
        end else if (adv && (ptr_q <= LAST_REG_ADDR)) begin
            ptr_d = (ptr_q == LAST_REG_ADDR) ? 4'h0 : ptr_q + 4'd1;
        end
    end

    // Pointer and auto-increment flag storage.
    always_ff @(posedge glb.clk) begin
        if (!glb.rst_n) begin
            ptr_q <= 4'h0;
            ai_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ai_q  <= ai_d;
        end
    end

    assign ptr = ptr_q;
    assign ai  = ai_q;

endmodule

// File: rtl/led_reg_file.sv
// rtl/led_reg_file.sv - LED controller register bank (optional readback: LED_REG_READBACK_EN)
module led_reg_file #(
    parameter int DATA_BITS = led_driver_pkg::DATA_BITS,
    parameter int NUM_REGS  = led_driver_pkg::NUM_REGS
) (
    global_if.sink                      glb,
    input  logic                        bus_start,
    input  logic                        bus_stop,
    input  logic                        wr_valid,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        rd_req,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_valid,
    output logic [DATA_BITS-1:0]        mode1_reg,
    output logic [DATA_BITS-1:0]        mode2_reg,
    output logic [3:0][DATA_BITS-1:0]   pwm_reg,
    output logic [DATA_BITS-1:0]        grp_pwm_reg,
    output logic [DATA_BITS-1:0]        grp_freq_reg,
    output logic [DATA_BITS-1:0]        ledout_reg,
    output logic                        dim_blink,
    output logic                        addr_err
);

    import led_driver_pkg::*;

    regfile_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] regs_q [NUM_REGS];
    logic                 addr_err_q, addr_err_d;
    logic                 ptr_load, ptr_adv, wr_fire;
    logic [3:0]           ptr;
    logic                 ai;
    logic                 ptr_ok;
    logic [DATA_BITS-1:0] wdata;
`ifdef LED_REG_READBACK_EN
    logic                 rd_fire;
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 rd_valid_q;
`endif

    assign ptr_ok = (ptr <= LAST_REG_ADDR);

    reg_pointer u_ptr (
        .glb      (glb),
        .load     (ptr_load),
        .load_val ({wr_data[7], wr_data[3:0]}),
        .adv      (ptr_adv),
        .ptr      (ptr),
        .ai       (ai)
    );

    // Bus FSM: start beats everything, stop lets a same-cycle data write land first.
    always_comb begin
        state_d    = state_q;
        addr_err_d = addr_err_q;
        ptr_load   = 1'b0;
        ptr_adv    = 1'b0;
        wr_fire    = 1'b0;
`ifdef LED_REG_READBACK_EN
        rd_fire    = 1'b0;
`endif
        if (bus_start) begin
            state_d    = CTRL;
            addr_err_d = 1'b0;
        end else begin
            case (state_q)
                CTRL: begin
                    if (wr_valid) begin
                        ptr_load = 1'b1;
                        state_d  = DATA;
                        if (wr_data[3:0] > LAST_REG_ADDR) begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (wr_valid) begin
                        wr_fire = 1'b1;
                        ptr_adv = ai;
`ifdef LED_REG_READBACK_EN
                    end else if (rd_req) begin
                        rd_fire = 1'b1;
                        ptr_adv = ai;
`endif
                    end
                end
                default: ;
            endcase
            if (bus_stop) begin
                state_d = IDLE;
            end
        end
    end

    // FSM state and sticky address-error flag.
    always_ff @(posedge glb.clk) begin
        if (!glb.rst_n) begin
            state_q    <= IDLE;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_err_q <= addr_err_d;
        end
    end

    // MODE2[7:6] are reserved and always stored as zero.
    always_comb begin
        wdata = wr_data;
        if (ptr == REG_MODE2) begin
            wdata[7:6] = 2'b00;
        end
    end

    // Register storage; writes to addresses beyond the map are dropped.
    always_ff @(posedge glb.clk) begin
        if (!glb.rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_BITS'(reg_reset_val(4'(i)));
            end
        end else if (wr_fire && ptr_ok) begin
            regs_q[ptr] <= wdata;
        end
    end

`ifdef LED_REG_READBACK_EN
    // Readback byte and one-cycle valid pulse; out-of-map pointers read as zero.
    always_ff @(posedge glb.clk) begin
        if (!glb.rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= ptr_ok ? regs_q[ptr] : '0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_rd_req;
    assign unused_rd_req = rd_req;
    assign rd_data       = '0;
    assign rd_valid      = 1'b0;
`endif

    assign mode1_reg    = regs_q[REG_MODE1];
    assign mode2_reg    = regs_q[REG_MODE2];
    assign pwm_reg[0]   = regs_q[REG_PWM0];
    assign pwm_reg[1]   = regs_q[REG_PWM1];
    assign pwm_reg[2]   = regs_q[REG_PWM2];
    assign pwm_reg[3]   = regs_q[REG_PWM3];
    assign grp_pwm_reg  = regs_q[REG_GRPPWM];
    assign grp_freq_reg = regs_q[REG_GRPFREQ];
    assign ledout_reg   = regs_q[REG_LEDOUT];
    assign dim_blink    = regs_q[REG_MODE2][5];
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_led_reg_file.sv
// tb/tb_led_reg_file.sv - directed self-checking bench for led_reg_file
module tb_led_reg_file;

    global_if glb ();

    logic            bus_start, bus_stop, wr_valid, rd_req;
    logic [7:0]      wr_data;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic [7:0]      mode1_reg, mode2_reg, grp_pwm_reg, grp_freq_reg, ledout_reg;
    logic [3:0][7:0] pwm_reg;
    logic            dim_blink, addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    led_reg_file dut (
        .glb          (glb),
        .bus_start    (bus_start),
        .bus_stop     (bus_stop),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .mode1_reg    (mode1_reg),
        .mode2_reg    (mode2_reg),
        .pwm_reg      (pwm_reg),
        .grp_pwm_reg  (grp_pwm_reg),
        .grp_freq_reg (grp_freq_reg),
        .ledout_reg   (ledout_reg),
        .dim_blink    (dim_blink),
        .addr_err     (addr_err)
    );

    initial glb.clk = 1'b0;
    always #5 glb.clk = ~glb.clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic wv, input logic [7:0] wd, input logic rr);
        bus_start = s;
        bus_stop  = p;
        wr_valid  = wv;
        wr_data   = wd;
        rd_req    = rr;
        @(posedge glb.clk);
        #1;
        bus_start = 1'b0;
        bus_stop  = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        rd_req    = 1'b0;
    endtask

    task automatic start();        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
    task automatic stop();         cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); endtask
    task automatic wr(input logic [7:0] b); cyc(1'b0, 1'b0, 1'b1, b, 1'b0); endtask
    task automatic rd();           cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask
    task automatic idle();         cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask

    initial begin
        bus_start = 1'b0; bus_stop = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
        glb.rst_n = 1'b0;
        repeat (2) @(posedge glb.clk);
        #1;
        chk("rst_grp_pwm",  grp_pwm_reg,  8'hFF);
        chk("rst_grp_freq", grp_freq_reg, 8'h00);
        chk("rst_mode1",    mode1_reg,    8'h11);
        chk("rst_mode2",    mode2_reg,    8'h01);
        chk("rst_dim",      dim_blink,    1'b0);
        chk("rst_rd_valid", rd_valid,     1'b0);
        chk("rst_addr_err", addr_err,     1'b0);
        glb.rst_n = 1'b1;
        idle();

        // auto-increment burst into GRPPWM/GRPFREQ, pointer then lands on LEDOUT
        start(); wr(8'h86); wr(8'h40); wr(8'h17);
        chk("burst_grp_pwm",  grp_pwm_reg,  8'h40);
        chk("burst_grp_freq", grp_freq_reg, 8'h17);
        wr(8'h5A);
        chk("burst_ptr8_ledout", ledout_reg, 8'h5A);
        stop();

        // wrap from ALLCALLADR to MODE1, then MODE2 with reserved bits dropped
        start(); wr(8'h8C); wr(8'hE6); wr(8'h01);
        chk("wrap_mode1", mode1_reg, 8'h01);
        wr(8'hC4);
        chk("wrap_mode2_rsvd", mode2_reg, 8'h04);
        chk("wrap_dim",        dim_blink, 1'b0);
        stop();

        // no auto-increment: both bytes land on MODE2
        start(); wr(8'h01); wr(8'h20);
        chk("noai_mode2_a", mode2_reg, 8'h20);
        chk("noai_dim_a",   dim_blink, 1'b1);
        wr(8'hE5);
        chk("noai_mode2_b", mode2_reg, 8'h25);
        chk("noai_dim_b",   dim_blink, 1'b1);
        chk("noai_mode1",   mode1_reg, 8'h01);
        stop();

        // invalid pointer: error flag, write ignored, flag sticky until next start
        start(); wr(8'h8E);
        chk("inv_addr_err", addr_err, 1'b1);
        wr(8'h55);
        chk("inv_mode1",    mode1_reg,    8'h01);
        chk("inv_mode2",    mode2_reg,    8'h25);
        chk("inv_pwm",      pwm_reg,      32'h0);
        chk("inv_grp_pwm",  grp_pwm_reg,  8'h40);
        chk("inv_grp_freq", grp_freq_reg, 8'h17);
        chk("inv_ledout",   ledout_reg,   8'h5A);
        stop();
        chk("inv_sticky",   addr_err, 1'b1);
        start();
        chk("inv_cleared",  addr_err, 1'b0);
        stop();

        // stop with a data write: write completes, later bytes in IDLE ignored
        start(); wr(8'h02);
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
        chk("stopwr_pwm0", pwm_reg[0], 8'h11);
        wr(8'h22);
        chk("idle_pwm0", pwm_reg[0], 8'h11);
        chk("idle_pwm1", pwm_reg[1], 8'h00);

        // start with a data byte: byte dropped, next byte is a control byte
        start(); wr(8'h03);
        cyc(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("startwr_pwm1", pwm_reg[1], 8'h00);
        wr(8'h04); wr(8'h99);
        chk("startwr_pwm2",   pwm_reg[2], 8'h99);
        chk("startwr_pwm1_b", pwm_reg[1], 8'h00);
        stop();

        start(); wr(8'h82); wr(8'hA1); wr(8'hB2); wr(8'hC3); wr(8'hD4);
        chk("pwm_burst", pwm_reg, 32'hD4C3B2A1);
        stop();

`ifdef LED_REG_READBACK_EN
        start(); wr(8'h82);
        rd(); chk("rb0_v", rd_valid, 1'b1); chk("rb0_d", rd_data, 8'hA1);
        rd(); chk("rb1_v", rd_valid, 1'b1); chk("rb1_d", rd_data, 8'hB2);
        rd(); chk("rb2_v", rd_valid, 1'b1); chk("rb2_d", rd_data, 8'hC3);
        rd(); chk("rb3_v", rd_valid, 1'b1); chk("rb3_d", rd_data, 8'hD4);
        idle(); chk("rb_pulse", rd_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        chk("wrrd_v",       rd_valid,    1'b0);
        chk("wrrd_grp_pwm", grp_pwm_reg, 8'h33);
        rd(); chk("wrrd_next_d", rd_data, 8'h17); chk("wrrd_next_v", rd_valid, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("startrd_v", rd_valid, 1'b0);
        wr(8'h8C);
        rd(); chk("rb_allcall", rd_data, 8'hE6);
        rd(); chk("rb_wrap_mode1", rd_data, 8'h01);
        start(); wr(8'h0F);
        chk("rb_inv_err", addr_err, 1'b1);
        rd(); chk("rb_inv_v", rd_valid, 1'b1); chk("rb_inv_d", rd_data, 8'h00);
        stop();
`else
        start(); wr(8'h82);
        rd(); chk("nrb_v", rd_valid, 1'b0); chk("nrb_d", rd_data, 8'h00);
        wr(8'h5C);
        chk("nrb_pwm0", pwm_reg[0], 8'h5C);
        stop();
`endif

        // reset in the middle of a transaction restores everything
        start(); wr(8'h86); wr(8'h12);
        chk("mid_grp_pwm", grp_pwm_reg, 8'h12);
        glb.rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        glb.rst_n = 1'b1;
        chk("mrst_grp_pwm",  grp_pwm_reg, 8'hFF);
        chk("mrst_mode1",    mode1_reg,   8'h11);
        chk("mrst_mode2",    mode2_reg,   8'h01);
        chk("mrst_pwm",      pwm_reg,     32'h0);
        chk("mrst_ledout",   ledout_reg,  8'h00);
        chk("mrst_rd_valid", rd_valid,    1'b0);
        wr(8'h66);
        chk("mrst_idle_wr",  grp_pwm_reg, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
